bus_transfer_scheduler: RTL and testbench

Sequencer and arbiter for the shared 32-bit register bus. Accepts register-to-register move requests from several requesters, such as the instruction decoder and the debug port, and grants them round-robin. For each granted move it drives the one-hot OutEnable/InEnable strobes of the register bank so that exactly one register drives the bus and exactly one register latches it. It sits between the control unit and the bank of Register instances.

---
 rtl/vic_bus_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/bus_transfer_scheduler.sv | 164 ++++++++++++++++
 tb/tb_bus_transfer_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vic_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vic_bus_pkg
// Description : Shared types, constants and the enable decode helper for the
//               32-bit register bus.
// Revision    : 1.0 - initial release
// ============================================================================
package vic_bus_pkg;

  localparam int BUS_W    = 32;
  localparam int MAX_REGS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LATCH = 2'd2
  } bus_state_t;

  // One-hot decode of a register index; out-of-range indices decode to zero.
  function automatic logic [MAX_REGS-1:0] onehot(input logic [31:0] idx, input int n);
    logic [MAX_REGS-1:0] w_vec;
    w_vec = '0;
    if (idx < 32'(n)) begin
      w_vec = MAX_REGS'(1) << idx[4:0];
    end
    return w_vec;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Picks the first asserted
//               request at or above ptr, wrapping around.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any
);

  // Requests rotated so that bit 0 is the requester at ptr.
  logic [N-1:0] w_rot;
  int           w_pos;

  assign w_rot = N'({req, req} >> ptr);

  // Scan the rotated requests from the pointer upward; first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    w_pos     = 0;
    for (int k = 0; k < N; k++) begin
      if (!any && w_rot[k]) begin
        any   = 1'b1;
        w_pos = int'(ptr) + k;
        if (w_pos >= N) begin
          w_pos = w_pos - N;
        end
        grant_idx = PW'(w_pos);
        grant     = N'(1) << w_pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_transfer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : bus_transfer_scheduler
// Description : Round-robin sequencer for register-to-register moves on the
//               shared bus. Drives one-hot OutEnable/InEnable strobes to the
//               register bank and reports completion per requester.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_transfer_scheduler
  import vic_bus_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int NUM_REQ  = 2,
  parameter int IDX_W    = $clog2(NUM_REGS),
  parameter int REQ_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*IDX_W-1:0] req_src,
  input  logic [NUM_REQ*IDX_W-1:0] req_dst,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REGS-1:0]      reg_out_enable,
  output logic [NUM_REGS-1:0]      reg_in_enable,
  output logic                     busy,
  output logic                     done,
  output logic [REQ_W-1:0]         done_id,
  output logic                     error
);

  // Index limit one bit wider than IDX_W so NUM_REGS itself is representable.
  localparam logic [IDX_W:0]   c_REG_LIMIT = (IDX_W+1)'(NUM_REGS);
  localparam logic [REQ_W-1:0] c_LAST_REQ  = REQ_W'(NUM_REQ - 1);

  bus_state_t            r_state;
  bus_state_t            w_nextState;
  logic [REQ_W-1:0]      r_rrPtr;
  logic [REQ_W-1:0]      r_id;
  logic [IDX_W-1:0]      r_src;
  logic [IDX_W-1:0]      r_dst;

  logic [NUM_REQ-1:0]    w_grant;
  logic [REQ_W-1:0]      w_grantIdx;
  logic                  w_grantAny;
  logic [IDX_W-1:0]      w_winSrc;
  logic [IDX_W-1:0]      w_winDst;
  logic                  w_legal;
  logic                  w_handshake;

  logic [NUM_REGS-1:0]   w_nextOutEn;
  logic [NUM_REGS-1:0]   w_nextInEn;
  logic                  w_nextDone;
  logic                  w_nextError;
  logic [REQ_W-1:0]      w_nextDoneId;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (REQ_W)
  ) u_arbiter (
    .req       (req_valid),
    .ptr       (r_rrPtr),
    .grant     (w_grant),
    .grant_idx (w_grantIdx),
    .any       (w_grantAny)
  );

  // Grants are only offered in IDLE and never while reset is held.
  assign req_ready   = (!reset && (r_state == IDLE) && w_grantAny) ? w_grant : '0;
  assign w_handshake = |req_ready;

  // Select the winning requester's source and destination indices.
  always_comb begin
    w_winSrc = '0;
    w_winDst = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_winSrc = req_src[i*IDX_W +: IDX_W];
        w_winDst = req_dst[i*IDX_W +: IDX_W];
      end
    end
  end

  assign w_legal = (w_winSrc != w_winDst) &&
                   ({1'b0, w_winSrc} < c_REG_LIMIT) &&
                   ({1'b0, w_winDst} < c_REG_LIMIT);

  // Next state plus next values of the registered strobes and status.
  always_comb begin
    w_nextState  = r_state;
    w_nextOutEn  = '0;
    w_nextInEn   = '0;
    w_nextDone   = 1'b0;
    w_nextError  = 1'b0;
    w_nextDoneId = done_id;
    case (r_state)
      IDLE: begin
        if (w_handshake) begin
          if (w_legal) begin
            w_nextState = DRIVE;
            w_nextOutEn = NUM_REGS'(onehot(32'(w_winSrc), NUM_REGS));
          end else begin
            // Rejected moves complete immediately with no bus activity.
            w_nextDone   = 1'b1;
            w_nextError  = 1'b1;
            w_nextDoneId = w_grantIdx;
          end
        end
      end
      DRIVE: begin
        w_nextState = LATCH;
        w_nextOutEn = NUM_REGS'(onehot(32'(r_src), NUM_REGS));
        w_nextInEn  = NUM_REGS'(onehot(32'(r_dst), NUM_REGS));
      end
      LATCH: begin
        w_nextState  = IDLE;
        w_nextDone   = 1'b1;
        w_nextDoneId = r_id;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Move capture, round-robin pointer and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rrPtr        <= '0;
      r_id           <= '0;
      r_src          <= '0;
      r_dst          <= '0;
      reg_out_enable <= '0;
      reg_in_enable  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      done_id        <= '0;
      error          <= 1'b0;
    end else begin
      if (w_handshake) begin
        r_src   <= w_winSrc;
        r_dst   <= w_winDst;
        r_id    <= w_grantIdx;
        r_rrPtr <= (w_grantIdx == c_LAST_REQ) ? '0 : w_grantIdx + 1'b1;
      end
      reg_out_enable <= w_nextOutEn;
      reg_in_enable  <= w_nextInEn;
      busy           <= (w_nextState != IDLE);
      done           <= w_nextDone;
      done_id        <= w_nextDoneId;
      error          <= w_nextError;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_transfer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_transfer_scheduler
// Description : Self-checking bench for bus_transfer_scheduler with a register
//               bank model and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_transfer_scheduler;

  localparam int NUM_REGS = 8;
  localparam int NUM_REQ  = 3;
  localparam int IDX_W    = 4;
  localparam int REQ_W    = 2;

  typedef struct {
    int cyc;
    int id;
    bit err;
  } doneEvent_t;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*IDX_W-1:0] req_src;
  logic [NUM_REQ*IDX_W-1:0] req_dst;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REGS-1:0]      reg_out_enable;
  logic [NUM_REGS-1:0]      reg_in_enable;
  logic                     busy;
  logic                     done;
  logic [REQ_W-1:0]         done_id;
  logic                     error;

  // Register bank contents as seen by the bench, and the model's expectation.
  logic [31:0] bankMem [NUM_REGS];
  logic [31:0] expMem  [NUM_REGS];

  int          vectorCount = 0;
  int          miscompareCount = 0;
  int          cycleNo = 0;
  int          modelPtr = 0;
  bit          mvActive = 1'b0;
  int          mvStart = 0;
  int          mvSrc = 0;
  int          mvDst = 0;
  doneEvent_t  doneQ[$];

  always #5 clock = ~clock;

  bus_transfer_scheduler #(
    .NUM_REGS (NUM_REGS),
    .NUM_REQ  (NUM_REQ),
    .IDX_W    (IDX_W),
    .REQ_W    (REQ_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_src        (req_src),
    .req_dst        (req_dst),
    .req_ready      (req_ready),
    .reg_out_enable (reg_out_enable),
    .reg_in_enable  (reg_in_enable),
    .busy           (busy),
    .done           (done),
    .done_id        (done_id),
    .error          (error)
  );

  task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectorCount++;
    if (got !== exp) begin
      miscompareCount++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cycleNo, got, exp);
    end
  endtask

  task automatic setReq(input int i, input bit v, input int s, input int d);
    req_valid[i]               = v;
    req_src[i*IDX_W +: IDX_W]  = IDX_W'(s);
    req_dst[i*IDX_W +: IDX_W]  = IDX_W'(d);
  endtask

  task automatic clearReqs();
    for (int i = 0; i < NUM_REQ; i++) setReq(i, 1'b0, 0, 0);
  endtask

  task automatic randomInputs();
    int s, d, mode;
    for (int i = 0; i < NUM_REQ; i++) begin
      s    = $urandom_range(0, NUM_REGS-1);
      d    = $urandom_range(0, NUM_REGS-1);
      mode = $urandom_range(0, 9);
      if (mode == 0) d = s;
      else if (mode == 1) s = $urandom_range(NUM_REGS, 15);
      else if (mode == 2) d = $urandom_range(NUM_REGS, 15);
      setReq(i, ($urandom_range(0, 99) < 50), s, d);
    end
    reset = ($urandom_range(0, 99) < 2);
  endtask

  // One clock cycle: check this cycle's outputs against the model, advance
  // the model, then let the bank react to the strobes at the posedge.
  task automatic runCycle();
    logic [NUM_REQ-1:0]  expReady;
    logic [NUM_REGS-1:0] expOut, expIn, outSnap, inSnap;
    logic [31:0]         busVal;
    int                  winner, r, s, d;
    bit                  idle, expDone, legal;
    #1;
    for (int i = 0; i < NUM_REGS; i++) begin
      checkValue($sformatf("mem[%0d]", i), bankMem[i], expMem[i]);
    end

    idle   = !(mvActive && (cycleNo <= mvStart + 2));
    expOut = '0;
    expIn  = '0;
    if (!idle) begin
      expOut[mvSrc] = 1'b1;
      if (cycleNo == mvStart + 2) expIn[mvDst] = 1'b1;
    end
    checkValue("out_enable", reg_out_enable, expOut);
    checkValue("in_enable", reg_in_enable, expIn);
    checkValue("busy", busy, !idle);

    while (doneQ.size() > 0 && doneQ[0].cyc < cycleNo) void'(doneQ.pop_front());
    expDone = (doneQ.size() > 0) && (doneQ[0].cyc == cycleNo);
    checkValue("done", done, expDone);
    if (expDone) begin
      checkValue("done_id", done_id, doneQ[0].id);
      checkValue("error", error, doneQ[0].err);
    end

    checkValue("onehot_out", $onehot0(reg_out_enable), 1);
    checkValue("onehot_in", $onehot0(reg_in_enable), 1);
    checkValue("in_without_out", (reg_in_enable != 0) && (reg_out_enable == 0), 0);
    checkValue("ready_while_busy", busy && (req_ready != 0), 0);

    winner = -1;
    if (!reset && idle) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        r = (modelPtr + k) % NUM_REQ;
        if (winner < 0 && req_valid[r]) winner = r;
      end
    end
    expReady = '0;
    if (winner >= 0) expReady[winner] = 1'b1;
    checkValue("req_ready", req_ready, expReady);

    // The destination is written at the edge ending LATCH, even under reset.
    if (mvActive && cycleNo == mvStart + 2) begin
      expMem[mvDst] = expMem[mvSrc];
      mvActive      = 1'b0;
    end
    if (reset) begin
      mvActive = 1'b0;
      modelPtr = 0;
      while (doneQ.size() > 0 && doneQ[$].cyc > cycleNo) void'(doneQ.pop_back());
    end else if (winner >= 0) begin
      s        = int'(req_src[winner*IDX_W +: IDX_W]);
      d        = int'(req_dst[winner*IDX_W +: IDX_W]);
      legal    = (s != d) && (s < NUM_REGS) && (d < NUM_REGS);
      modelPtr = (winner + 1) % NUM_REQ;
      if (legal) begin
        mvActive = 1'b1;
        mvStart  = cycleNo;
        mvSrc    = s;
        mvDst    = d;
        doneQ.push_back('{cycleNo + 3, winner, 1'b0});
      end else begin
        doneQ.push_back('{cycleNo + 1, winner, 1'b1});
      end
    end

    outSnap = reg_out_enable;
    inSnap  = reg_in_enable;
    @(posedge clock);
    if (inSnap != 0) begin
      busVal = '0;
      for (int i = 0; i < NUM_REGS; i++) if (outSnap[i]) busVal = bankMem[i];
      for (int i = 0; i < NUM_REGS; i++) if (inSnap[i]) bankMem[i] = busVal;
    end
    #1;
    cycleNo++;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_src   = '0;
    req_dst   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      bankMem[i] = $urandom;
      expMem[i]  = bankMem[i];
    end
    bankMem[2] = 32'hDEADBEEF;
    expMem[2]  = 32'hDEADBEEF;

    @(posedge clock);
    #1;
    repeat (2) runCycle();
    checkValue("reset_done_id", done_id, 0);
    checkValue("reset_error", error, 0);
    reset = 1'b0;

    // Single move R2 -> R5.
    setReq(0, 1'b1, 2, 5);
    runCycle();
    clearReqs();
    repeat (4) runCycle();
    checkValue("single_move_R5", bankMem[5], 32'hDEADBEEF);

    // Contention with the pointer back at 0.
    reset = 1'b1;
    runCycle();
    reset = 1'b0;
    setReq(0, 1'b1, 1, 4);
    setReq(1, 1'b1, 3, 6);
    repeat (12) runCycle();
    clearReqs();
    repeat (3) runCycle();

    // Illegal moves: src == dst, then an out-of-range source.
    setReq(0, 1'b1, 3, 3);
    runCycle();
    clearReqs();
    repeat (2) runCycle();
    setReq(0, 1'b1, 9, 1);
    runCycle();
    clearReqs();
    repeat (2) runCycle();

    // Withdrawal: requester 1 asks while busy and drops before IDLE.
    setReq(0, 1'b1, 0, 7);
    runCycle();
    setReq(0, 1'b0, 0, 0);
    setReq(1, 1'b1, 4, 2);
    runCycle();
    setReq(1, 1'b0, 0, 0);
    repeat (4) runCycle();

    // Reset during DRIVE: no write, no done.
    setReq(0, 1'b1, 1, 6);
    runCycle();
    clearReqs();
    reset = 1'b1;
    runCycle();
    reset = 1'b0;
    repeat (3) runCycle();

    // Reset during LATCH: write lands, no done.
    setReq(0, 1'b1, 3, 0);
    runCycle();
    clearReqs();
    runCycle();
    reset = 1'b1;
    runCycle();
    reset = 1'b0;
    repeat (3) runCycle();

    // Randomized traffic.
    repeat (3000) begin
      randomInputs();
      runCycle();
    end
    reset = 1'b0;
    clearReqs();
    repeat (5) runCycle();

    for (int i = 0; i < NUM_REGS; i++) begin
      checkValue($sformatf("final_mem[%0d]", i), bankMem[i], expMem[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
`default_nettype wire
